// File: rtl/parser_pkg.sv
// Shared sizes, field typedefs and the 16-bit header extraction helper for the
// parser extract stage.
package parser_pkg;

  localparam int HEAD_BYTES        = 64;
  localparam int KEY_FIELD_NUM     = 8;
  localparam int KEY_OFFSET_WIDTH  = 6;
  localparam int TYPE_NUM          = 4;
  localparam int TYPE_WIDTH        = 16;
  localparam int TYPE_OFFSET_WIDTH = 6;
  localparam int META_SLOTS        = 16;
  localparam int HEAD_SHIFT_WIDTH  = 7;
  localparam int META_SHIFT_WIDTH  = 5;

  localparam int HEAD_W = HEAD_BYTES * 8;
  localparam int META_W = META_SLOTS * 16;
  localparam int KEY_W  = KEY_OFFSET_WIDTH + 1;

  typedef struct packed {
    logic                        vld;
    logic [KEY_OFFSET_WIDTH-1:0] off;
  } key_off_t;

  typedef logic [TYPE_WIDTH-1:0] type_t;
  typedef logic [15:0]           meta_slot_t;

  // Bytes [byte_off, byte_off+1] of head (byte 0 at MSBs); bytes past the end read 0.
  function automatic logic [15:0] get_half(input logic [HEAD_W-1:0] head,
                                           input logic [7:0]        byte_off);
    logic [HEAD_W+15:0] ext;
    ext = {head, 16'h0000} << {byte_off, 3'b000};
    return ext[HEAD_W+15 -: 16];
  endfunction

endpackage

// File: rtl/parser_byte_shifter.sv
// Left byte barrel shifter, byte 0 at MSBs, zero fill. Shifts of BYTES or more
// give all zeros because every stage shifts bits fully out of the vector.
module parser_byte_shifter #(
  parameter int BYTES   = 64,
  parameter int SHIFT_W = 7
) (
  input  logic [BYTES*8-1:0] data_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic [BYTES*8-1:0] data_o
);

  logic [SHIFT_W:0][BYTES*8-1:0] stg;

  assign stg[0] = data_i;

  for (genvar s = 0; s < SHIFT_W; s++) begin : g_stage
    assign stg[s+1] = shift_i[s] ? (stg[s] << (8 * (2 ** s))) : stg[s];
  end

  assign data_o = stg[SHIFT_W];

endmodule

// File: rtl/parser_extract_stage.sv
// Two-stage parser extract: stage 1 pulls key fields into metadata and strips the
// header, stage 2 pulls next-layer type fields from the stripped header.
module parser_extract_stage
  import parser_pkg::*;
(
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_valid,
  output logic                                  o_ready,
  input  logic [HEAD_W-1:0]                     i_head,
  input  logic [META_W-1:0]                     i_meta,
  input  logic [KEY_FIELD_NUM*KEY_W-1:0]        i_keyOffset,
  input  logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0] i_typeOffset,
  input  logic [HEAD_SHIFT_WIDTH-1:0]           i_headShift,
  input  logic [META_SHIFT_WIDTH-1:0]           i_metaShift,
  output logic                                  o_valid,
  input  logic                                  i_ready,
  output logic [HEAD_W-1:0]                     o_head,
  output logic [META_W-1:0]                     o_meta,
  output logic [TYPE_NUM*TYPE_WIDTH-1:0]        o_type,
  output logic [31:0]                           o_pkt_cnt,
  output logic                                  o_err,
  input  logic                                  i_err_clr
);

  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe_q;
  logic            en1, en2, range_err, err_set;
  logic            err_q;
  logic [31:0]     pkt_cnt_q;

  key_off_t   [KEY_FIELD_NUM-1:0]                    key_off;
  logic       [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]  type_off, s1_toff_q;
  logic       [HEAD_W-1:0]                           head_d, s1_head_q, o_head_q;
  meta_slot_t [META_SLOTS-1:0]                       meta_d, s1_meta_q, o_meta_q;
  type_t      [TYPE_NUM-1:0]                         type_d, o_type_q;

  // o_ready is intentionally a pure combinational function of i_ready and the valids.
  assign en2     = ~vld_pipe_q[2] | i_ready;
  assign en1     = ~vld_pipe_q[1] | en2;
  assign o_ready = en1;
  assign o_valid = vld_pipe_q[2];

  assign key_off  = i_keyOffset;
  assign type_off = i_typeOffset;

  parser_byte_shifter #(
    .BYTES  (HEAD_BYTES),
    .SHIFT_W(HEAD_SHIFT_WIDTH)
  ) u_head_shift (
    .data_i (i_head),
    .shift_i(i_headShift),
    .data_o (head_d)
  );

  // Slot 0 sits at the LSBs, so a left shift moves slot k up to k+shift.
  always_comb begin
    meta_d = i_meta << {i_metaShift, 4'b0000};
    for (int j = 0; j < KEY_FIELD_NUM; j++) begin
      if (key_off[j].vld) meta_d[j] = get_half(i_head, 8'(key_off[j].off));
    end
  end

  always_comb begin
    for (int t = 0; t < TYPE_NUM; t++) begin
      type_d[t] = get_half(s1_head_q, 8'(s1_toff_q[t]));
    end
  end

  assign range_err = (i_headShift > 7'(HEAD_BYTES)) || (i_metaShift > 5'(META_SLOTS));
  assign err_set   = i_valid & en1 & range_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_pipe_q <= '0;
    end else begin
      if (en1) vld_pipe_q[1] <= i_valid;
      if (en2) vld_pipe_q[2] <= vld_pipe_q[1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_head_q <= '0;
      s1_meta_q <= '0;
      s1_toff_q <= '0;
    end else if (i_valid & en1) begin
      s1_head_q <= head_d;
      s1_meta_q <= meta_d;
      s1_toff_q <= type_off;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_head_q <= '0;
      o_meta_q <= '0;
      o_type_q <= '0;
    end else if (vld_pipe_q[1] & en2) begin
      o_head_q <= s1_head_q;
      o_meta_q <= s1_meta_q;
      o_type_q <= type_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pkt_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (o_valid & i_ready) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      err_q <= err_set | (err_q & ~i_err_clr);
    end
  end

  assign o_head    = o_head_q;
  assign o_meta    = o_meta_q;
  assign o_type    = o_type_q;
  assign o_pkt_cnt = pkt_cnt_q;
  assign o_err     = err_q;

endmodule

// File: doc/parser_extract_stage.md
Name: parser_extract_stage

Overview:
- Parser stage directly downstream of the type-lookup stage. Consumes its lookup result: key offsets, type offsets, header shift and meta shift.
- Per header beat it extracts 16-bit key fields into the metadata slot vector and strips consumed bytes from the header.
- It also extracts the next layer's type fields, which feed the following stage's type lookup.
- 2-stage valid/ready pipeline; one whole header per beat.

Parameters:
- HEAD_BYTES, 64, header vector size in bytes.
- KEY_FIELD_NUM, 8, key fields per rule; each is 16 bits.
- KEY_OFFSET_WIDTH, 6, byte offset of a key field. Each key offset port carries an extra top bit that is the valid flag.
- TYPE_NUM, 4, number of next-layer type fields.
- TYPE_WIDTH, 16, type field width in bits.
- TYPE_OFFSET_WIDTH, 6, byte offset of a type field, relative to the shifted header.
- META_SLOTS, 16, number of 16-bit metadata slots.
- HEAD_SHIFT_WIDTH, 7, header shift in bytes (0..127).
- META_SHIFT_WIDTH, 5, metadata shift in slots (0..31).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_valid  in  1  input beat valid
- o_ready  out  1  stage can accept a beat
- i_head  in  HEAD_BYTES*8  header; byte 0 is at the MSBs
- i_meta  in  META_SLOTS*16  metadata; slot 0 is at the LSBs
- i_keyOffset  in  KEY_FIELD_NUM*(KEY_OFFSET_WIDTH+1)  per field: {valid, byte offset}
- i_typeOffset  in  TYPE_NUM*TYPE_OFFSET_WIDTH  next-layer type byte offsets
- i_headShift  in  HEAD_SHIFT_WIDTH  bytes to strip
- i_metaShift  in  META_SHIFT_WIDTH  slots to shift metadata up
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts
- o_head  out  HEAD_BYTES*8  shifted header
- o_meta  out  META_SLOTS*16  updated metadata
- o_type  out  TYPE_NUM*TYPE_WIDTH  next-layer type fields
- o_pkt_cnt  out  32  beats delivered
- o_err  out  1  sticky: an accepted shift was out of range
- i_err_clr  in  1  clears o_err

Behaviour:
- Reset: i_rst_n asynchronous, active-low; clock i_clk. On reset, all pipeline valids, o_valid, o_head, o_meta, o_type, o_pkt_cnt and o_err go to 0.
- Handshake:
  - en2 = ~s2_valid | i_ready.
  - en1 = ~s1_valid | en2.
  - o_ready = en1. This is a combinational path from i_ready; it is accepted and must contain no other logic.
  - Beats are never dropped or duplicated. Data and valid on the outputs stay stable while o_valid & ~i_ready.
- Latency: 2 cycles from accept to o_valid when unstalled. Throughput: 1 beat per cycle.
- Stage 1, captured on i_valid & en1:
  - Key j: if valid bit is 1, key = i_head bytes [off, off+1]. Any byte index >= HEAD_BYTES reads 0.
  - Metadata: shift i_meta up by i_metaShift slots (slot k -> k+shift). Slots >= META_SLOTS are dropped; vacated slots become 0.
  - Each valid key j then overwrites slot j. Invalid keys leave the shifted slot untouched.
  - Header: shift left by i_headShift bytes with zero fill. A shift >= HEAD_BYTES yields all zeros.
  - Out-of-range shift: i_headShift > HEAD_BYTES or i_metaShift > META_SLOTS sets the err flag carried with the beat.
  - A beat with all keys invalid and both shifts 0 (a lookup miss) passes through unchanged.
- Stage 2, captured on s1_valid & en2:
  - o_type[t] = shifted header bytes [off_t, off_t+1], with out-of-range bytes reading 0.
  - o_head and o_meta are registered through from stage 1.
  - If s1_valid is 0 while en2 is 1, the stage-2 valid clears.
- o_pkt_cnt: increments on o_valid & i_ready; wraps from 0xFFFF_FFFF to 0.
- o_err:
  - Set when an errored beat is accepted into stage 1.
  - i_err_clr clears it.
  - Set wins over clear in the same cycle.
- Reset mid-operation: in-flight beats are discarded and o_valid deasserts immediately.

Decomposition:
- Package parser_pkg holds:
  - The size constants above.
  - Typedefs key_off_t ({valid, offset}), type_t, meta_slot_t.
  - A function get_half(head, byte_off) returning 16 bits with zero fill past the end.
- Sub-module parser_byte_shifter: parameterised left byte barrel shift with zero fill and saturating shift amount. It is instantiated for the header path; metadata slot shifting is done inline.

Test Plan:
- Reset release, then i_valid=1 with i_head bytes 0..63 = 0x00..0x3F, key0 = {1,12}, other keys invalid, headShift=14, metaShift=0, typeOffset0=0:
  - o_valid arrives exactly 2 cycles later.
  - meta slot0 = 0x0C0D.
  - o_head byte0 = 0x0E and bytes 50..63 = 0.
  - o_type[0] = 0x0E0F.
  - o_pkt_cnt = 1.
- i_meta slots 0..15 = 0x1000+k, metaShift=2, key1 = {1,0} with head bytes 0..1 = 0xAAAA:
  - slot1 = 0xAAAA.
  - slot0 = 0.
  - slot2 = 0x1000.
  - slot15 = 0x100D.
- Boundaries:
  - key offset 63 -> key = {byte63, 0x00}.
  - headShift=64 -> o_head all zero, o_err stays 0.
  - headShift=65 -> o_err = 1.
  - i_err_clr pulsed with no new error -> o_err = 0.
  - Error and clear in the same cycle -> o_err stays 1.
- Back-to-back: 10 beats with i_ready toggling randomly.
  - Outputs appear in order, none lost or duplicated, held stable while stalled.
  - o_ready = 0 only when both stages are full and i_ready = 0.
  - o_pkt_cnt = 10.
- Lookup miss: all keys invalid, both shifts 0 -> o_head == i_head and o_meta == i_meta.
- Assert i_rst_n = 0 with 2 beats in flight -> o_valid = 0 at once. After release, a new beat emerges with correct data and o_pkt_cnt restarts from 0.
